capture_scheduler: RTL and testbench
====================================

# capture_scheduler

Round-robin scheduler that shares one capture/hold datapath register between `NREQ` requesters. It arbitrates among the pending requests and latches the winner's data word and index. It then holds the resource busy for a fixed number of cycles and signals completion. It sits in front of the wide concatenated `y` result buses and feeds them one registered `{data, id, valid}` snapshot at a time.

## Interface
- `NREQ`, 4: number of requesters, 2..16.
- `DW`, 9: data width per requester.
- `HOLD`, 3: cycles the resource stays granted per transaction, ≥1.
- `IW`: derived, `$clog2(NREQ)`; not user-set.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  NREQ  request per requester; bit i = requester i.
- `data`  in  NREQ*DW  requester i word at `[i*DW +: DW]`.
- `gnt`  out  NREQ  one-hot grant, registered.
- `busy`  out  1  high while any grant is held, registered.
- `done`  out  1  one-cycle completion pulse, registered.
- `y`  out  DW+IW+1  `{cap_data, cap_id, cap_valid}`, all registered.

## Operation
- Two states: IDLE and BUSY. Internal regs: `ptr` (IW bits), `cnt` (`$clog2(HOLD)` bits, min 1), `cap_data`, `cap_id`, `cap_valid`.
- IDLE, `req`==0: hold everything; `done` returns to 0.
- IDLE, `req`!=0: the winner is the first set bit scanning upward from `ptr`, wrapping at `NREQ-1`→0. On that edge:
  - state←BUSY, `gnt`←onehot(winner), `busy`←1, `cnt`←HOLD-1.
  - `cap_id`←winner, `cap_data`←that requester's `data`, `cap_valid`←0.
- BUSY, `cnt`!=0: `cnt` decrements; `req`, `data` and `ptr` are ignored.
- BUSY, `cnt`==0: state←IDLE, `gnt`←0, `busy`←0, `done`←1, `cap_valid`←1, `ptr`←(`cap_id`+1) mod NREQ.
- `done` is 1 for exactly one cycle, the first IDLE cycle after a grant.
- Requesters hold `req` until they see their `gnt`. Dropping `req` during BUSY does not abort the transaction.
- A requester still asserting `req` after its own transaction is eligible again, but only after all others pending at that point (round-robin fairness).
- `ptr` wraps NREQ-1→0. A non-power-of-2 `NREQ` never yields an index ≥NREQ.
- `cap_data`/`cap_id` persist until the next grant. `cap_valid` marks them as completed.

## Timing
- Reset, asynchronous: `gnt`=0, `busy`=0, `done`=0, `y`=0, `ptr`=0, state IDLE.
- Reset asserted mid-BUSY drops `gnt` immediately with no `done`. The first grant after release arbitrates from `ptr`=0.
- Latency: `req` sampled at IDLE edge k; `gnt`/`busy` are high from edge k through edge k+HOLD (HOLD cycles).
- `done`/`cap_valid` rise at edge k+HOLD.
- Earliest next grant is edge k+HOLD+1. Sustained throughput is one transaction per HOLD+1 cycles.
- `gnt` is never multi-hot and never changes while `busy`=1.

## Configuration
- `CAPTURE_SCHED_PRIO0_EN`: if defined, requester 0 wins any IDLE arbitration in which `req[0]`=1, regardless of `ptr`. `ptr` still updates to `cap_id`+1 on completion.
- If undefined, arbitration is pure round-robin as described above.

## Test plan
- Reset, then `req`=4'b0001, `data[0]`=9'h1A5, HOLD=3 → `gnt`=0001 for 3 cycles; then `done`=1 for 1 cycle; `y`={9'h1A5, 2'd0, 1'b1}.
- `req`=4'b1111 held constant → grant order 0,1,2,3,0; each grant 3 cycles, 1-cycle gap; `ptr` wraps 3→0.
- `req`=4'b1010 after ptr=2 → requester 3 first, then 1; `cap_id` 3 then 1; `gnt` never multi-hot.
- Assert `rst_n`=0 at the 2nd BUSY cycle → `gnt`, `busy`, `y` go to 0 asynchronously; no `done`; next grant for `req`=4'b0110 goes to requester 1.
- Drop `req` mid-BUSY → transaction completes, `done` still pulses, `cap_valid`=1.
- With `CAPTURE_SCHED_PRIO0_EN` and `req`=4'b1111 held → requester 0 wins every arbitration; without the macro, rotation as in the second scenario.

Source files
------------

// File: rtl/capture_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : capture_scheduler
// Purpose  : Round-robin arbiter in front of one shared capture/hold register.
//            Optional macro CAPTURE_SCHED_PRIO0_EN gives requester 0 priority.
// Revision : 1.0 - initial release
// ============================================================================
module capture_scheduler #(
  parameter int NREQ = 4,
  parameter int DW   = 9,
  parameter int HOLD = 3,
  localparam int IW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DW-1:0]   data,
  output logic [NREQ-1:0]      gnt,
  output logic                 busy,
  output logic                 done,
  output logic [DW+IW:0]       y
);

  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [DW-1:0]   cap_data_q, cap_data_d;
  logic [IW-1:0]   cap_id_q, cap_id_d;
  logic            cap_valid_q, cap_valid_d;

  logic            hi_found;
  logic [IW-1:0]   hi_idx;
  logic [IW-1:0]   lo_idx;
  logic [IW-1:0]   win_idx;
  logic [DW-1:0]   win_data;

  // Winner = lowest request at/above ptr, else lowest request overall (wrap).
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_idx = IW'(i);
        if (IW'(i) >= ptr_q) begin
          hi_found = 1'b1;
          hi_idx   = IW'(i);
        end
      end
    end
    win_idx = hi_found ? hi_idx : lo_idx;
`ifdef CAPTURE_SCHED_PRIO0_EN
    if (req[0]) begin
      win_idx = '0;
    end
`endif
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == IW'(i)) begin
        win_data = data[i*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    busy_d      = busy_q;
    done_d      = done_q;
    cap_data_d  = cap_data_q;
    cap_id_d    = cap_id_q;
    cap_valid_d = cap_valid_q;
    case (state_q)
      S_IDLE: begin
        done_d = 1'b0;
        if (req != '0) begin
          state_d     = S_BUSY;
          gnt_d       = NREQ'(1) << win_idx;
          busy_d      = 1'b1;
          cnt_d       = CW'(HOLD - 1);
          cap_id_d    = win_idx;
          cap_data_d  = win_data;
          cap_valid_d = 1'b0;
        end
      end
      S_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d     = S_IDLE;
          gnt_d       = '0;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          cap_valid_d = 1'b1;
          ptr_d       = (cap_id_q == IW'(NREQ - 1)) ? '0 : cap_id_q + IW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cap_data_q  <= '0;
      cap_id_q    <= '0;
      cap_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cap_data_q  <= cap_data_d;
      cap_id_q    <= cap_id_d;
      cap_valid_q <= cap_valid_d;
    end
  end

  assign gnt  = gnt_q;
  assign busy = busy_q;
  assign done = done_q;
  assign y    = {cap_data_q, cap_id_q, cap_valid_q};

endmodule
`default_nettype wire

// File: tb/tb_capture_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_capture_scheduler
// Purpose  : Directed self-checking bench for capture_scheduler (NREQ=4, DW=9, HOLD=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_capture_scheduler;

  localparam int NREQ = 4;
  localparam int DW   = 9;
  localparam int HOLD = 3;
  localparam int IW   = 2;

  logic                clk;
  logic                rst_n;
  logic [NREQ-1:0]     req;
  logic [NREQ*DW-1:0]  data;
  logic [NREQ-1:0]     gnt;
  logic                busy;
  logic                done;
  logic [DW+IW:0]      y;

  int n_cmp;
  int n_err;

  capture_scheduler #(
    .NREQ (NREQ),
    .DW   (DW),
    .HOLD (HOLD)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .data  (data),
    .gnt   (gnt),
    .busy  (busy),
    .done  (done),
    .y     (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One full transaction from an IDLE negedge; ends on the negedge showing done.
  task automatic run_txn(input int id, input logic [DW-1:0] d, input bit drop);
    logic [IW-1:0] idv;
    idv = IW'(id);
    tick();
    check("grant_gnt",  32'(gnt),  32'(4'b0001 << id));
    check("grant_busy", 32'(busy), 32'd1);
    check("grant_done", 32'(done), 32'd0);
    check("grant_y",    32'(y),    32'({d, idv, 1'b0}));
    if (drop) begin
      req  = '0;
      data = ~data;
    end
    repeat (HOLD - 1) begin
      tick();
      check("hold_gnt",  32'(gnt),  32'(4'b0001 << id));
      check("hold_busy", 32'(busy), 32'd1);
    end
    tick();
    check("end_gnt",  32'(gnt),  32'd0);
    check("end_busy", 32'(busy), 32'd0);
    check("end_done", 32'(done), 32'd1);
    check("end_y",    32'(y),    32'({d, idv, 1'b1}));
    if (drop) begin
      data = ~data;
    end
  endtask

  int order [5];

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    req   = '0;
    data  = {9'h1F4, 9'h033, 9'h122, 9'h1A5};
    repeat (2) @(negedge clk);
    check("rst_gnt",  32'(gnt),  32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_y",    32'(y),    32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_gnt", 32'(gnt), 32'd0);

    // single requester, captured word 1A5
    req = 4'b0001;
    run_txn(0, 9'h1A5, 1'b1);
    tick();
    check("done_pulse", 32'(done), 32'd0);
    check("y_persist",  32'(y),    32'({9'h1A5, 2'd0, 1'b1}));

    // all requesting from ptr=0
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    req   = 4'b1111;
`ifdef CAPTURE_SCHED_PRIO0_EN
    order = '{0, 0, 0, 0, 0};
`else
    order = '{0, 1, 2, 3, 0};
`endif
    for (int t = 0; t < 5; t++) begin
      run_txn(order[t], data[order[t]*DW +: DW], 1'b0);
    end

    // move ptr to 2, then req=1010 -> 3 then 1
    req = 4'b0010;
    run_txn(1, 9'h122, 1'b0);
    req = 4'b1010;
    run_txn(3, 9'h1F4, 1'b0);
    run_txn(1, 9'h122, 1'b0);

    // req and data dropped/changed mid-BUSY are ignored
    req = 4'b0100;
    run_txn(2, 9'h033, 1'b1);

    // reset during second BUSY cycle
    req = 4'b1000;
    tick();
    check("pre_rst_gnt", 32'(gnt), 32'b1000);
    tick();
    rst_n = 1'b0;
    #1;
    check("arst_gnt",  32'(gnt),  32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_y",    32'(y),    32'd0);
    check("arst_done", 32'(done), 32'd0);
    tick();
    check("rst_hold_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    req   = 4'b0110;
    run_txn(1, 9'h122, 1'b0);

    req = '0;
    tick();
    check("final_done", 32'(done), 32'd0);
    check("final_gnt",  32'(gnt),  32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
